// File: rtl/tcm_mem_dport_bist_if.sv
// TCM data-port request/response bundle between the BIST initiator (master) and the TCM (slave).
interface tcm_mem_dport_bist_if;
  logic [31:0] mem_d_addr_o;
  logic [31:0] mem_d_data_wr_o;
  logic        mem_d_rd_o;
  logic [3:0]  mem_d_wr_o;
  logic        mem_d_cacheable_o;
  logic        mem_d_invalidate_o;
  logic        mem_d_writeback_o;
  logic        mem_d_flush_o;
  logic [10:0] mem_d_req_tag_o;
  logic [31:0] mem_d_data_rd_i;
  logic        mem_d_accept_i;
  logic        mem_d_ack_i;
  logic        mem_d_error_i;
  logic [10:0] mem_d_resp_tag_i;

  modport master (
    output mem_d_addr_o, mem_d_data_wr_o, mem_d_rd_o, mem_d_wr_o,
    output mem_d_cacheable_o, mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o,
    output mem_d_req_tag_o,
    input  mem_d_data_rd_i, mem_d_accept_i, mem_d_ack_i, mem_d_error_i, mem_d_resp_tag_i
  );

  modport slave (
    input  mem_d_addr_o, mem_d_data_wr_o, mem_d_rd_o, mem_d_wr_o,
    input  mem_d_cacheable_o, mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o,
    input  mem_d_req_tag_o,
    output mem_d_data_rd_i, mem_d_accept_i, mem_d_ack_i, mem_d_error_i, mem_d_resp_tag_i
  );
endinterface

// File: rtl/tcm_mem_dport_bist.sv
// TCM data-port BIST: writes a pattern over a word range, reads it back and checks every word.
// Define TCM_BIST_LFSR_EN for a Galois LFSR pattern; otherwise the pattern is (address ^ seed).
module tcm_mem_dport_bist #(
  parameter  int unsigned TIMEOUT = 16,
  localparam int unsigned AW      = 32,
  localparam int unsigned DW      = 32,
  localparam int unsigned CW      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AW-1:0]        base_addr_i,
  input  logic [CW-1:0]        num_words_i,
  input  logic [DW-1:0]        seed_i,
  tcm_mem_dport_bist_if.master mem_d,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [CW-1:0]        err_count_o,
  output logic [AW-1:0]        first_err_addr_o
);

  localparam int unsigned TW    = 11;
  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CW-1:0]    ERR_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e          r_state, w_state_n;
  logic [AW-1:0]   r_base, w_base_n;
  logic [CW-1:0]   r_count, w_count_n;
  logic [DW-1:0]   r_seed, w_seed_n;
  logic [CW-1:0]   r_idx, w_idx_n;
  logic [TMO_W-1:0] r_tmo, w_tmo_n;
  logic [DW-1:0]   r_pat, w_pat_n;
  logic [AW-1:0]   r_addr, w_addr_n;
  logic [DW-1:0]   r_wdata, w_wdata_n;
  logic            r_rd, w_rd_n;
  logic [3:0]      r_wr, w_wr_n;
  logic [TW-1:0]   r_tag, w_tag_n;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;
  logic            r_pass, w_pass_n;
  logic            r_timeout, w_timeout_n;
  logic [CW-1:0]   r_err_cnt, w_err_cnt_n;
  logic [AW-1:0]   r_first_err, w_first_err_n;

  logic [AW-1:0]   w_base_aligned;
  logic [AW-1:0]   w_addr_inc;
  logic [CW-1:0]   w_idx_inc;
  logic [DW-1:0]   w_pat_start;
  logic [DW-1:0]   w_pat_next;
  logic [DW-1:0]   w_pat_reload;
  logic            w_word_fail;
  logic            w_last;

  assign w_base_aligned = base_addr_i & 32'hFFFF_FFFC;
  assign w_addr_inc     = r_addr + 32'd4;
  assign w_idx_inc      = r_idx + 16'd1;
  assign w_last         = (w_idx_inc == r_count);

  // r_pat always holds P(i) for the word currently requested
`ifdef TCM_BIST_LFSR_EN
  localparam logic [DW-1:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  assign w_pat_start  = (seed_i == '0) ? 32'd1 : seed_i;
  assign w_pat_next   = lfsr_step(r_pat);
  assign w_pat_reload = (r_seed == '0) ? 32'd1 : r_seed;
`else
  assign w_pat_start  = w_base_aligned ^ seed_i;
  assign w_pat_next   = w_addr_inc ^ r_seed;
  assign w_pat_reload = r_base ^ r_seed;
`endif

  // next-state and registered-output computation
  always_comb begin
    w_state_n     = r_state;
    w_base_n      = r_base;
    w_count_n     = r_count;
    w_seed_n      = r_seed;
    w_idx_n       = r_idx;
    w_tmo_n       = r_tmo;
    w_pat_n       = r_pat;
    w_addr_n      = r_addr;
    w_wdata_n     = r_wdata;
    w_rd_n        = r_rd;
    w_wr_n        = r_wr;
    w_tag_n       = r_tag;
    w_busy_n      = r_busy;
    w_done_n      = 1'b0;
    w_pass_n      = r_pass;
    w_timeout_n   = r_timeout;
    w_err_cnt_n   = r_err_cnt;
    w_first_err_n = r_first_err;
    w_word_fail   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_base_n      = w_base_aligned;
          w_count_n     = num_words_i;
          w_seed_n      = seed_i;
          w_idx_n       = '0;
          w_tmo_n       = '0;
          w_pat_n       = w_pat_start;
          w_err_cnt_n   = '0;
          w_first_err_n = '0;
          w_timeout_n   = 1'b0;
          w_pass_n      = 1'b0;
          w_busy_n      = 1'b1;
          if (num_words_i == '0) begin
            w_state_n = S_DONE;
            w_done_n  = 1'b1;
            w_pass_n  = 1'b1;
          end else begin
            w_state_n = S_WR_REQ;
            w_addr_n  = w_base_aligned;
            w_wdata_n = w_pat_start;
            w_wr_n    = 4'hF;
            w_tag_n   = '0;
          end
        end
      end

      S_WR_REQ, S_RD_REQ: begin
        if (mem_d.mem_d_accept_i) begin
          w_rd_n    = 1'b0;
          w_wr_n    = 4'h0;
          w_tmo_n   = '0;
          w_state_n = (r_state == S_WR_REQ) ? S_WR_WAIT : S_RD_WAIT;
        end
      end

      S_WR_WAIT, S_RD_WAIT: begin
        if (mem_d.mem_d_ack_i) begin
          w_word_fail = mem_d.mem_d_error_i ||
                        ((r_state == S_RD_WAIT) &&
                         ((mem_d.mem_d_data_rd_i != r_pat) ||
                          (mem_d.mem_d_resp_tag_i != r_idx[TW-1:0])));
          if (w_last && (r_state == S_RD_WAIT)) begin
            w_state_n = S_DONE;
            w_done_n  = 1'b1;
            w_pass_n  = (r_err_cnt == '0) && !w_word_fail && !r_timeout;
          end else if (w_last) begin
            w_state_n = S_RD_REQ;
            w_idx_n   = '0;
            w_addr_n  = r_base;
            w_pat_n   = w_pat_reload;
            w_wdata_n = '0;
            w_rd_n    = 1'b1;
            w_tag_n   = '0;
          end else begin
            w_idx_n  = w_idx_inc;
            w_addr_n = w_addr_inc;
            w_pat_n  = w_pat_next;
            w_tag_n  = w_idx_inc[TW-1:0];
            if (r_state == S_WR_WAIT) begin
              w_state_n = S_WR_REQ;
              w_wdata_n = w_pat_next;
              w_wr_n    = 4'hF;
            end else begin
              w_state_n = S_RD_REQ;
              w_wdata_n = '0;
              w_rd_n    = 1'b1;
            end
          end
        end else if (r_tmo == TMO_LAST) begin
          w_state_n   = S_DONE;
          w_timeout_n = 1'b1;
          w_done_n    = 1'b1;
          w_pass_n    = 1'b0;
        end else begin
          w_tmo_n = r_tmo + TMO_W'(1);
        end
      end

      S_DONE: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // a word counts once however many checks it failed
    if (w_word_fail) begin
      if (r_err_cnt != ERR_MAX) begin
        w_err_cnt_n = r_err_cnt + 16'd1;
      end
      if (r_err_cnt == '0) begin
        w_first_err_n = r_addr;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_count     <= '0;
      r_seed      <= '0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_pat       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 4'h0;
      r_tag       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      r_state     <= w_state_n;
      r_base      <= w_base_n;
      r_count     <= w_count_n;
      r_seed      <= w_seed_n;
      r_idx       <= w_idx_n;
      r_tmo       <= w_tmo_n;
      r_pat       <= w_pat_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_rd        <= w_rd_n;
      r_wr        <= w_wr_n;
      r_tag       <= w_tag_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
      r_pass      <= w_pass_n;
      r_timeout   <= w_timeout_n;
      r_err_cnt   <= w_err_cnt_n;
      r_first_err <= w_first_err_n;
    end
  end

  assign mem_d.mem_d_addr_o       = r_addr;
  assign mem_d.mem_d_data_wr_o    = r_wdata;
  assign mem_d.mem_d_rd_o         = r_rd;
  assign mem_d.mem_d_wr_o         = r_wr;
  assign mem_d.mem_d_req_tag_o    = r_tag;
  assign mem_d.mem_d_cacheable_o  = 1'b0;
  assign mem_d.mem_d_invalidate_o = 1'b0;
  assign mem_d.mem_d_writeback_o  = 1'b0;
  assign mem_d.mem_d_flush_o      = 1'b0;

  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign timeout_o        = r_timeout;
  assign err_count_o      = r_err_cnt;
  assign first_err_addr_o = r_first_err;

endmodule
